// File: rtl/msrv32_csr_file.sv
// msrv32_csr_file: machine-mode CSR file with Zicsr read-modify-write, 64-bit counters, trap entry and mret handling.
//   clk_in/rst_in        : clock, synchronous active-high reset
//   wr_en_in             : flush-gated CSR write enable
//   csr_addr_in/csr_op_in: CSR address and funct3
//   rs1_in/imm_in        : register and zero-extended immediate sources
//   pc_in/trap_in/cause_in/tval_in : trap entry request and its state
//   mret_in              : mret retiring
//   instret_inc_in       : instruction retired
//   e_irq_in/t_irq_in/s_irq_in : level interrupt lines
//   csr_data_out/illegal_csr_out : old CSR value and illegal-access flag
//   mepc_out/trap_address_out/mie_out/irq_pending_out : trap/return info for PC mux and control
module msrv32_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_en_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic [31:0] rs1_in,
    input  logic [4:0]  imm_in,
    input  logic [31:0] pc_in,
    input  logic        trap_in,
    input  logic [31:0] cause_in,
    input  logic [31:0] tval_in,
    input  logic        mret_in,
    input  logic        instret_inc_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    output logic [31:0] mepc_out,
    output logic [31:0] trap_address_out,
    output logic        mie_out,
    output logic        irq_pending_out
);
    logic        r_mie_bit, r_mpie, r_meip, r_mtip, r_msip;
    logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [63:0] r_mcycle, r_minstret;
    logic [31:0] w_src, w_mstatus, w_mip, w_old, w_new, w_base;
    logic [63:0] w_cyc_inc, w_ins_inc;
    logic        w_impl, w_ro, w_op_ok, w_writes, w_wr;

    assign w_src     = csr_op_in[2] ? {27'd0, imm_in} : rs1_in;
    assign w_op_ok   = csr_op_in[1:0] != 2'b00;
    // set/clear forms with a zero source are pure reads
    assign w_writes  = (csr_op_in[1:0] == 2'b01) || (w_src != 32'd0);
    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_bit, 3'd0};
    assign w_mip     = {20'd0, r_meip, 3'd0, r_mtip, 3'd0, r_msip, 3'd0};

    always_comb begin
        w_impl = 1'b1;
        w_old  = 32'd0;
        case (csr_addr_in)
            12'h300: w_old = w_mstatus;
            12'h301: w_old = MISA_VALUE;
            12'h304: w_old = r_mie;
            12'h305: w_old = r_mtvec;
            12'h340: w_old = r_mscratch;
            12'h341: w_old = r_mepc;
            12'h342: w_old = r_mcause;
            12'h343: w_old = r_mtval;
            12'h344: w_old = w_mip;
            12'hB00, 12'hC00: w_old = r_mcycle[31:0];
            12'hB80, 12'hC80: w_old = r_mcycle[63:32];
            12'hB02, 12'hC02: w_old = r_minstret[31:0];
            12'hB82, 12'hC82: w_old = r_minstret[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: w_old = 32'd0;
            default: w_impl = 1'b0;
        endcase
    end

    assign w_ro = (csr_addr_in[11:10] == 2'b11) || (csr_addr_in == 12'h301) || (csr_addr_in == 12'h344);
    assign illegal_csr_out = !w_op_ok || !w_impl || (w_writes && w_ro);
    assign csr_data_out = w_old;
    assign w_new = (csr_op_in[1:0] == 2'b01) ? w_src :
                   (csr_op_in[1:0] == 2'b10) ? (w_old | w_src) : (w_old & ~w_src);
    // trap and mret take precedence over any coincident CSR write
    assign w_wr = wr_en_in && !illegal_csr_out && w_writes && !trap_in && !mret_in;

    assign w_base = {r_mtvec[31:2], 2'b00};
    assign trap_address_out = (r_mtvec[1:0] == 2'b01 && cause_in[31]) ?
                              w_base + {cause_in[29:0], 2'b00} : w_base;
    assign mepc_out = r_mepc;
    assign mie_out = r_mie_bit;
    assign irq_pending_out = r_mie_bit && |(r_mie & w_mip);

    assign w_cyc_inc = r_mcycle + 64'd1;
    assign w_ins_inc = r_minstret + {63'd0, instret_inc_in};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mie_bit  <= 1'b0;
            r_mpie     <= 1'b0;
            r_meip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_msip     <= 1'b0;
            r_mie      <= 32'd0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            r_meip     <= e_irq_in;
            r_mtip     <= t_irq_in;
            r_msip     <= s_irq_in;
            // a counter-word write below overrides only that word; the other keeps the increment
            r_mcycle   <= w_cyc_inc;
            r_minstret <= w_ins_inc;
            if (trap_in) begin
                r_mepc    <= {pc_in[31:2], 2'b00};
                r_mcause  <= cause_in;
                r_mtval   <= tval_in;
                r_mpie    <= r_mie_bit;
                r_mie_bit <= 1'b0;
            end else if (mret_in) begin
                r_mie_bit <= r_mpie;
                r_mpie    <= 1'b1;
            end else if (w_wr) begin
                case (csr_addr_in)
                    12'h300: begin
                        r_mie_bit <= w_new[3];
                        r_mpie    <= w_new[7];
                    end
                    12'h304: r_mie <= w_new & 32'h0000_0888;
                    // only direct (0) and vectored (1) modes are kept
                    12'h305: r_mtvec <= {w_new[31:2], 1'b0, w_new[1:0] == 2'b01};
                    12'h340: r_mscratch <= w_new;
                    12'h341: r_mepc <= {w_new[31:2], 2'b00};
                    12'h342: r_mcause <= w_new;
                    12'h343: r_mtval <= w_new;
                    12'hB00: r_mcycle[31:0] <= w_new;
                    12'hB80: r_mcycle[63:32] <= w_new;
                    12'hB02: r_minstret[31:0] <= w_new;
                    12'hB82: r_minstret[63:32] <= w_new;
                    default: ;
                endcase
            end
        end
    end
endmodule
